// File: rtl/input_focus_ctrl.sv
// input_focus_ctrl: turns debounced push-button levels into single-cycle
// cursor/char command pulses with typematic auto-repeat, owns the one-hot
// focus enable across NUM_BOXES input boxes, and emits a tagged submit strobe.
module input_focus_ctrl #(
    parameter int unsigned NUM_BOXES    = 2,
    parameter int unsigned REPEAT_DELAY = 12_500_000,
    parameter int unsigned REPEAT_RATE  = 2_500_000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_next,
    input  logic                 btn_submit,
    output logic                 cursor_left,
    output logic                 cursor_right,
    output logic                 char_up,
    output logic                 char_dn,
    output logic [NUM_BOXES-1:0] en,
    output logic [2:0]           focus_idx,
    output logic                 submit_valid,
    output logic [2:0]           submit_idx
);

    localparam logic [2:0]       LAST_IDX   = 3'(NUM_BOXES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    state_t           state;
    dir_t             winner;
    dir_t             win_sel;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cmd;      // {char_up, char_dn, cursor_right, cursor_left}

    // History of each button level; armed is low for the first clock after
    // reset so a button held through reset release never looks like an edge.
    logic hist_left, hist_right, hist_up, hist_down, hist_next, hist_submit;
    logic armed;

    logic edge_left, edge_right, edge_up, edge_down, edge_next, edge_submit;
    logic any_dir_edge;
    logic held;
    logic [2:0] focus_nxt;

    // One-hot command vector for a direction.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] v;
        v = 4'b0000;
        case (d)
            DIR_UP:    v = 4'b1000;
            DIR_DOWN:  v = 4'b0100;
            DIR_RIGHT: v = 4'b0010;
            DIR_LEFT:  v = 4'b0001;
            default:   v = 4'b0000;
        endcase
        return v;
    endfunction

    // Rising edges, priority winner, held level of the latched winner, next focus.
    always_comb begin
        edge_left    = armed & btn_left   & ~hist_left;
        edge_right   = armed & btn_right  & ~hist_right;
        edge_up      = armed & btn_up     & ~hist_up;
        edge_down    = armed & btn_down   & ~hist_down;
        edge_next    = armed & btn_next   & ~hist_next;
        edge_submit  = armed & btn_submit & ~hist_submit;
        any_dir_edge = edge_left | edge_right | edge_up | edge_down;

        win_sel = DIR_LEFT;
        if (edge_up)         win_sel = DIR_UP;
        else if (edge_down)  win_sel = DIR_DOWN;
        else if (edge_right) win_sel = DIR_RIGHT;

        held = 1'b0;
        case (winner)
            DIR_UP:    held = btn_up;
            DIR_DOWN:  held = btn_down;
            DIR_RIGHT: held = btn_right;
            DIR_LEFT:  held = btn_left;
            default:   held = 1'b0;
        endcase

        focus_nxt = (focus_idx == LAST_IDX) ? 3'd0 : focus_idx + 3'd1;
    end

    // Edge history, direction FSM with repeat counter, focus and submit registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_left    <= 1'b0;
            hist_right   <= 1'b0;
            hist_up      <= 1'b0;
            hist_down    <= 1'b0;
            hist_next    <= 1'b0;
            hist_submit  <= 1'b0;
            armed        <= 1'b0;
            state        <= ST_IDLE;
            winner       <= DIR_LEFT;
            cnt          <= '0;
            cmd          <= 4'b0000;
            en           <= NUM_BOXES'(1);
            focus_idx    <= 3'd0;
            submit_valid <= 1'b0;
            submit_idx   <= 3'd0;
        end else begin
            hist_left    <= btn_left;
            hist_right   <= btn_right;
            hist_up      <= btn_up;
            hist_down    <= btn_down;
            hist_next    <= btn_next;
            hist_submit  <= btn_submit;
            armed        <= 1'b1;
            cmd          <= 4'b0000;
            submit_valid <= edge_submit;
            if (edge_submit) begin
                submit_idx <= focus_idx;
            end

            if (edge_next) begin
                // Focus change aborts any repeat so no command reaches two boxes.
                focus_idx <= focus_nxt;
                en        <= NUM_BOXES'(1) << focus_nxt;
                state     <= ST_IDLE;
                cnt       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_dir_edge) begin
                            winner <= win_sel;
                            cmd    <= dir_onehot(win_sel);
                            cnt    <= DELAY_LOAD;
                            state  <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (!held) begin
                            state <= ST_IDLE;
                        end else if (cnt == '0) begin
                            cmd   <= dir_onehot(winner);
                            cnt   <= RATE_LOAD;
                            state <= ST_REPEAT;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!held) begin
                            state <= ST_IDLE;
                        end else if (cnt == '0) begin
                            cmd <= dir_onehot(winner);
                            cnt <= RATE_LOAD;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign char_up      = cmd[3];
    assign char_dn      = cmd[2];
    assign cursor_right = cmd[1];
    assign cursor_left  = cmd[0];

endmodule

// File: tb/tb_input_focus_ctrl.sv
// Scoreboard bench for input_focus_ctrl: stimulus pushes expected pulses
// (cycle + kind) into queues; a negedge monitor pops and compares them.
module tb_input_focus_ctrl;

    localparam int unsigned NB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic          btn_next = 1'b0, btn_submit = 1'b0;
    logic          cursor_left, cursor_right, char_up, char_dn;
    logic [NB-1:0] en;
    logic [2:0]    focus_idx;
    logic          submit_valid;
    logic [2:0]    submit_idx;

    localparam logic [3:0] C_UP = 4'b1000, C_DN = 4'b0100, C_RT = 4'b0010, C_LT = 4'b0001;

    typedef struct { int cyc; logic [3:0] cmd; } cmd_exp_t;
    typedef struct { int cyc; logic [2:0] idx; } sub_exp_t;

    cmd_exp_t cmd_q[$];
    sub_exp_t sub_q[$];
    cmd_exp_t ce;
    sub_exp_t se;
    logic [3:0] act_cmd;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    input_focus_ctrl #(
        .NUM_BOXES    (NB),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2),
        .CNT_W        (24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_next     (btn_next),
        .btn_submit   (btn_submit),
        .cursor_left  (cursor_left),
        .cursor_right (cursor_right),
        .char_up      (char_up),
        .char_dn      (char_dn),
        .en           (en),
        .focus_idx    (focus_idx),
        .submit_valid (submit_valid),
        .submit_idx   (submit_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_cmd(input int offset, input logic [3:0] c);
        cmd_exp_t e;
        e.cyc = cyc + offset;
        e.cmd = c;
        cmd_q.push_back(e);
    endtask

    task automatic exp_sub(input int offset, input logic [2:0] idx);
        sub_exp_t e;
        e.cyc = cyc + offset;
        e.idx = idx;
        sub_q.push_back(e);
    endtask

    task automatic check_state(input string name, input int exp_en, input int exp_focus);
        check({name, "_en"}, int'(en), exp_en);
        check({name, "_focus"}, int'(focus_idx), exp_focus);
    endtask

    // Monitor: every presented pulse must match the head of its queue.
    always @(negedge clk) begin
        act_cmd = {char_up, char_dn, cursor_right, cursor_left};
        if (act_cmd != 4'b0000) begin
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected actual=%b required=none (cycle %0d)", act_cmd, cyc);
            end else begin
                ce = cmd_q.pop_front();
                check("cmd_cycle", cyc, ce.cyc);
                check("cmd_kind", int'(act_cmd), int'(ce.cmd));
            end
        end
        if (submit_valid) begin
            if (sub_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL submit_unexpected actual=%0d required=none (cycle %0d)", submit_idx, cyc);
            end else begin
                se = sub_q.pop_front();
                check("submit_cycle", cyc, se.cyc);
                check("submit_idx", int'(submit_idx), int'(se.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_cmd", int'({char_up, char_dn, cursor_right, cursor_left}), 0);
        check_state("rst", 1, 0);
        check("rst_submit_valid", int'(submit_valid), 0);
        check("rst_submit_idx", int'(submit_idx), 0);
        rst = 1'b1;
        tick(2);

        // 1: single-cycle up press -> one char_up
        btn_up = 1'b1; exp_cmd(1, C_UP);
        tick(1);
        btn_up = 1'b0;
        tick(8);
        check_state("t1", 1, 0);

        // 2: held right -> pulses at 1, 5, 7, 9, 11
        btn_right = 1'b1;
        exp_cmd(1, C_RT); exp_cmd(5, C_RT); exp_cmd(7, C_RT); exp_cmd(9, C_RT); exp_cmd(11, C_RT);
        tick(12);
        btn_right = 1'b0;
        tick(6);

        // 3: up+left together -> up wins; left held after up release stays silent
        btn_up = 1'b1; btn_left = 1'b1; exp_cmd(1, C_UP);
        tick(3);
        btn_up = 1'b0;
        tick(6);
        btn_left = 1'b0;
        tick(2);
        btn_left = 1'b1; exp_cmd(1, C_LT);
        tick(1);
        btn_left = 1'b0;
        tick(4);

        // 4: focus walk 001 -> 010 -> 100 -> 001
        btn_next = 1'b1; tick(1); check_state("t4a", 3'b010, 1); btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(1); check_state("t4b", 3'b100, 2); btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(1); check_state("t4c", 3'b001, 0); btn_next = 1'b0; tick(1);

        // 4b: next during held down mid-repeat suppresses the due pulse
        btn_down = 1'b1;
        exp_cmd(1, C_DN); exp_cmd(5, C_DN); exp_cmd(7, C_DN);
        tick(8);
        btn_next = 1'b1;
        tick(1);
        check_state("t4d", 3'b010, 1);
        btn_next = 1'b0;
        tick(6);
        btn_down = 1'b0;
        tick(2);

        // 5: held submit -> one pulse tagged 1; next+submit same cycle -> tag 1, focus 2
        btn_submit = 1'b1; exp_sub(1, 3'd1);
        tick(5);
        btn_submit = 1'b0;
        tick(2);
        btn_next = 1'b1; btn_submit = 1'b1; exp_sub(1, 3'd1);
        tick(1);
        check_state("t5", 3'b100, 2);
        btn_next = 1'b0; btn_submit = 1'b0;
        tick(2);

        // Direction edge coinciding with a next edge is dropped; focus wraps to 0
        btn_next = 1'b1; btn_left = 1'b1;
        tick(1);
        check_state("drop", 3'b001, 0);
        btn_next = 1'b0;
        tick(5);
        btn_left = 1'b0;
        tick(2);
        btn_next = 1'b1; tick(1); check_state("pre6", 3'b010, 1); btn_next = 1'b0; tick(2);

        // 6: reset during repeat with down held; no pulse on release while held
        btn_down = 1'b1;
        exp_cmd(1, C_DN); exp_cmd(5, C_DN); exp_cmd(7, C_DN);
        tick(8);
        rst = 1'b0;
        #1;
        check("t6_cmd", int'({char_up, char_dn, cursor_right, cursor_left}), 0);
        check_state("t6", 1, 0);
        check("t6_submit_idx", int'(submit_idx), 0);
        tick(3);
        rst = 1'b1;
        tick(10);
        btn_down = 1'b0;
        tick(2);
        btn_down = 1'b1; exp_cmd(1, C_DN);
        tick(1);
        btn_down = 1'b0;
        tick(4);

        check("cmd_q_left", cmd_q.size(), 0);
        check("sub_q_left", sub_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
